// File: rtl/ma_cvxif_issue_sched_if.sv
// ma_cvxif_issue_sched_if
// Purpose: bundles the CV-X-IF issue/commit/result channels and the
//          accelerator dispatch channel seen by the issue scheduler.
// Modports:
//   slave  - the scheduler (receives issue/commit/acc handshake inputs,
//            drives ready/accept/dispatch/result outputs)
//   master - the environment (core + accelerator side)
// Parameters: XLEN (operand/result width), IdWidth (instruction id width).
interface ma_cvxif_issue_sched_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IdWidth = 4
);
  // issue channel
  logic               issue_valid_i;
  logic               issue_ready_o;
  logic [31:0]        issue_instr_i;
  logic [IdWidth-1:0] issue_id_i;
  logic [XLEN-1:0]    issue_rs1_i;
  logic [XLEN-1:0]    issue_rs2_i;
  logic               issue_accept_o;
  logic               issue_we_o;
  // commit channel
  logic               commit_valid_i;
  logic [IdWidth-1:0] commit_id_i;
  logic               commit_kill_i;
  // accelerator dispatch/completion
  logic               acc_valid_o;
  logic               acc_ready_i;
  logic [31:0]        acc_instr_o;
  logic [XLEN-1:0]    acc_rs1_o;
  logic [XLEN-1:0]    acc_rs2_o;
  logic               acc_done_i;
  logic [XLEN-1:0]    acc_result_i;
  // result channel
  logic               result_valid_o;
  logic               result_ready_i;
  logic [IdWidth-1:0] result_id_o;
  logic [XLEN-1:0]    result_data_o;
  logic               result_we_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
    output issue_ready_o, issue_accept_o, issue_we_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output acc_valid_o, acc_instr_o, acc_rs1_o, acc_rs2_o,
    input  acc_ready_i, acc_done_i, acc_result_i,
    output result_valid_o, result_id_o, result_data_o, result_we_o,
    input  result_ready_i
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
    input  issue_ready_o, issue_accept_o, issue_we_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  acc_valid_o, acc_instr_o, acc_rs1_o, acc_rs2_o,
    output acc_ready_i, acc_done_i, acc_result_i,
    input  result_valid_o, result_id_o, result_data_o, result_we_o,
    output result_ready_i
  );
endinterface

// File: rtl/ma_cvxif_issue_sched.sv
// ma_cvxif_issue_sched
// Purpose: CV-X-IF issue scheduler in front of the matrix accelerator.
//   Accepts custom-opcode instructions into an in-order queue, tracks
//   commit/kill per entry, dispatches committed head entries one at a time
//   to the accelerator and returns exactly one result per committed op.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - ma_cvxif_issue_sched_if.slave (issue, commit, acc, result)
module ma_cvxif_issue_sched #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned Depth    = 4,
  parameter logic [6:0]  MaOpcode = 7'h0B
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  ma_cvxif_issue_sched_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    BUSY     = 2'd2,
    RESP     = 2'd3
  } state_t;

  // queue payload (no reset needed: only read while the entry is valid)
  logic [31:0]        instr_reg [Depth];
  logic [IdWidth-1:0] id_reg    [Depth];
  logic [XLEN-1:0]    rs1_reg   [Depth];
  logic [XLEN-1:0]    rs2_reg   [Depth];
  // per-entry status
  logic               we_reg        [Depth];
  logic               committed_reg [Depth];
  logic               killed_reg    [Depth];

  logic [Depth-1:0]   entry_valid;
  logic [Depth-1:0]   commit_hit;

  logic [PtrW-1:0]    head_reg;
  logic [PtrW-1:0]    tail_reg;
  logic [CntW-1:0]    count_reg;

  state_t             state_reg;
  state_t             state_next;
  logic [XLEN-1:0]    result_reg;

  logic               issue_ready;
  logic               is_ours;
  logic               push;
  logic               push_we;
  logic               pop;
  logic               capture;
  logic               acc_valid;
  logic               result_valid;
  logic               head_valid;
  logic               head_committed;
  logic               head_killed;

  // ---------------------------------------------------------------------
  // issue handshake: accept/we are combinational on the handshake cycle
  // ---------------------------------------------------------------------
  assign issue_ready = (count_reg < CntW'(Depth));
  assign is_ours     = (bus.issue_instr_i[6:0] == MaOpcode);
  assign push        = bus.issue_valid_i & issue_ready & is_ours;
  assign push_we     = push & bus.issue_instr_i[14] & (|bus.issue_instr_i[11:7]);

  assign bus.issue_ready_o  = issue_ready;
  assign bus.issue_accept_o = push;
  assign bus.issue_we_o     = push_we;

  // ---------------------------------------------------------------------
  // queue entries
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    logic [PtrW-1:0] offset;

    // distance from head (wraps because Depth is a power of two)
    assign offset          = PtrW'(gi) - head_reg;
    assign entry_valid[gi] = (CntW'(offset) < count_reg);
    // a push can only target a free slot, so it never collides with a hit
    assign commit_hit[gi]  = bus.commit_valid_i & entry_valid[gi] &
                             ~committed_reg[gi] & ~killed_reg[gi] &
                             (id_reg[gi] == bus.commit_id_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        we_reg[gi]        <= 1'b0;
        committed_reg[gi] <= 1'b0;
        killed_reg[gi]    <= 1'b0;
      end else if (push && (tail_reg == PtrW'(gi))) begin
        we_reg[gi]        <= push_we;
        committed_reg[gi] <= 1'b0;
        killed_reg[gi]    <= 1'b0;
      end else if (commit_hit[gi]) begin
        committed_reg[gi] <= ~bus.commit_kill_i;
        killed_reg[gi]    <= bus.commit_kill_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push && (tail_reg == PtrW'(gi))) begin
        instr_reg[gi] <= bus.issue_instr_i;
        id_reg[gi]    <= bus.issue_id_i;
        rs1_reg[gi]   <= bus.issue_rs1_i;
        rs2_reg[gi]   <= bus.issue_rs2_i;
      end
    end
  end

  assign head_valid     = (count_reg != '0);
  assign head_committed = committed_reg[head_reg];
  assign head_killed    = killed_reg[head_reg];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PtrW'(1);
      if (pop)  head_reg <= head_reg + PtrW'(1);
      count_reg <= count_reg + CntW'(push) - CntW'(pop);
    end
  end

  // ---------------------------------------------------------------------
  // head FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (head_valid && !head_killed && head_committed) state_next = DISPATCH;
      DISPATCH: if (bus.acc_ready_i)    state_next = BUSY;
      BUSY:     if (bus.acc_done_i)     state_next = RESP;
      RESP:     if (bus.result_ready_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_valid    = 1'b0;
    result_valid = 1'b0;
    capture      = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      IDLE:     pop = head_valid & head_killed;  // drop killed ops one per cycle
      DISPATCH: acc_valid = 1'b1;
      BUSY:     capture = bus.acc_done_i;        // done outside BUSY is ignored
      RESP: begin
        result_valid = 1'b1;
        pop          = bus.result_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      result_reg <= '0;
    else if (capture) result_reg <= bus.acc_result_i;
  end

  // outputs are forced to zero whenever their valid is low
  assign bus.acc_valid_o    = acc_valid;
  assign bus.acc_instr_o    = acc_valid ? instr_reg[head_reg] : '0;
  assign bus.acc_rs1_o      = acc_valid ? rs1_reg[head_reg]   : '0;
  assign bus.acc_rs2_o      = acc_valid ? rs2_reg[head_reg]   : '0;

  assign bus.result_valid_o = result_valid;
  assign bus.result_id_o    = result_valid ? id_reg[head_reg] : '0;
  assign bus.result_data_o  = result_valid ? result_reg       : '0;
  assign bus.result_we_o    = result_valid & we_reg[head_reg];

endmodule
